// File: rtl/md_pkg.sv
// md_pkg: shared types and defaults for the multiply/divide unit.
//   md_func_t  - operation code issued by EX alongside the start pulse
//   md_state_t - md_unit sequencing state
//   MD_WIDTH / MD_MUL_LAT - default operand width and multiply latency
package md_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_MUL_LAT = 3;

    typedef enum logic [2:0] {
        FN_NONE = 3'd0,
        FN_MULT = 3'd1,
        FN_DIV  = 3'd2,
        FN_MTHI = 3'd3,
        FN_MTLO = 3'd4,
        FN_MADD = 3'd5,
        FN_MSUB = 3'd6,
        FN_RSVD = 3'd7
    } md_func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_if.sv
// md_if: EX <-> multiply/divide unit bundle.
//   master (EX side) drives : start, func, isSign, a, b, flush
//   slave  (md_unit) drives : busy, done, hi, lo
interface md_if import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) ();

    logic             start;
    logic [2:0]       func;
    logic             isSign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, func, isSign, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, func, isSign, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/md_divider.sv
// md_divider: iterative restoring radix-2 divider on unsigned magnitudes.
//   i_start    - load operands; the first quotient bit is produced on this edge
//   i_abort    - drop any division in progress
//   i_dividend, i_divisor - operand magnitudes
//   o_quo, o_rem - quotient / remainder magnitudes, held after completion
//   o_valid    - one-cycle pulse once all WIDTH quotient bits are formed
module md_divider import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The subtraction is done
    // at WIDTH bits because the difference is always below the divisor.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0]   tmp;
        logic [WIDTH-1:0] nrem;
        logic [WIDTH-1:0] nquo;
        tmp = {rem, quo[WIDTH-1]};
        if (tmp >= {1'b0, dvs}) begin
            nrem = tmp[WIDTH-1:0] - dvs;
            nquo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            nrem = tmp[WIDTH-1:0];
            nquo = {quo[WIDTH-2:0], 1'b0};
        end
        return {nrem, nquo};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_abort) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            {r_rem, r_quo} <= div_step('0, i_dividend, i_divisor);
            r_div          <= i_divisor;
            r_cnt          <= CW'(WIDTH - 1);
            r_valid        <= (WIDTH == 1);
        end else if (r_cnt != '0) begin
            {r_rem, r_quo} <= div_step(r_rem, r_quo, r_div);
            r_cnt          <= r_cnt - 1'b1;
            r_valid        <= (r_cnt == CW'(1));
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_quo   = r_quo;
    assign o_rem   = r_rem;
    assign o_valid = r_valid;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - md_if.slave: start/func/isSign/a/b/flush in, busy/done/hi/lo out
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; MTHI/MTLO complete here in one edge
// ST_MUL  | product travelling down the MUL_LAT-deep pipeline
// ST_DIV  | divider core forming one quotient bit per cycle
// ST_FIX  | apply signs / zero / overflow rules and write HI/LO
module md_unit import md_pkg::*; #(
    parameter int WIDTH   = MD_WIDTH,
    parameter int MUL_LAT = MD_MUL_LAT
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);

    md_state_t          r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    md_func_t           r_mul_op;
    logic [2*WIDTH-1:0] r_mul_data [MUL_LAT];
    logic [MUL_LAT-1:0] r_mul_vld;
    logic               r_div_zero;
    logic               r_div_ovf;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_div_a;

    md_func_t           w_func;
    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc_add;
    logic [2*WIDTH-1:0] w_acc_sub;
    logic               w_div_start;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_valid;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_min;

    assign w_func   = md_func_t'(bus.func);
    assign w_accept = bus.start & ~bus.flush & (r_state == ST_IDLE);
    assign w_min    = {1'b1, {(WIDTH-1){1'b0}}};

    // Extending both operands to 2*WIDTH and keeping the low half of the
    // product gives the correct two's-complement result for signed and
    // unsigned operands alike.
    assign w_a_ext = bus.isSign ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign w_b_ext = bus.isSign ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Accumulate against HI/LO as they stand at completion, not at issue.
    assign w_acc_add = {r_hi, r_lo} + r_mul_data[MUL_LAT-1];
    assign w_acc_sub = {r_hi, r_lo} - r_mul_data[MUL_LAT-1];

    assign w_a_neg     = bus.isSign & bus.a[WIDTH-1];
    assign w_b_neg     = bus.isSign & bus.b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag     = w_b_neg ? -bus.b : bus.b;
    assign w_div_start = w_accept & (w_func == FN_DIV);

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (bus.flush),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quo      (w_div_quo),
        .o_rem      (w_div_rem),
        .o_valid    (w_div_valid)
    );

    assign w_quo_fix = r_neg_q ? -w_div_quo : w_div_quo;
    assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mul_op   <= FN_NONE;
            r_mul_vld  <= '0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_a    <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_mul_data[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_mul_data[i] <= r_mul_data[i-1];
                r_mul_vld[i]  <= r_mul_vld[i-1];
            end
            r_mul_vld[0] <= 1'b0;

            if (bus.flush) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_mul_vld <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            case (w_func)
                                FN_MTHI: r_hi <= bus.a;
                                FN_MTLO: r_lo <= bus.a;
                                FN_MULT, FN_MADD, FN_MSUB: begin
                                    r_mul_op      <= w_func;
                                    r_mul_data[0] <= w_prod;
                                    r_mul_vld[0]  <= 1'b1;
                                    r_state       <= ST_MUL;
                                    r_busy        <= 1'b1;
                                end
                                FN_DIV: begin
                                    r_div_zero <= (bus.b == '0);
                                    r_div_ovf  <= bus.isSign & (bus.a == w_min) & (bus.b == '1);
                                    r_neg_q    <= w_a_neg ^ w_b_neg;
                                    r_neg_r    <= w_a_neg;
                                    r_div_a    <= bus.a;
                                    r_state    <= ST_DIV;
                                    r_busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (r_mul_vld[MUL_LAT-1]) begin
                            case (r_mul_op)
                                FN_MADD: {r_hi, r_lo} <= w_acc_add;
                                FN_MSUB: {r_hi, r_lo} <= w_acc_sub;
                                default: {r_hi, r_lo} <= r_mul_data[MUL_LAT-1];
                            endcase
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DIV: begin
                        if (w_div_valid) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (r_div_zero) begin
                            r_lo <= '1;
                            r_hi <= r_div_a;
                        end else if (r_div_ovf) begin
                            r_lo <= w_min;
                            r_hi <= '0;
                        end else begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a behavioural HI/LO model.
module tb_md_unit;
    import md_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    md_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    // Architectural effect of one accepted operation, from the arithmetic rules.
    function automatic void model_op(input logic [2:0] fn, input logic sg,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [63:0] acc;
        int sa;
        int sb;
        if (sg) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else    p = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        case (fn)
            3'd1: {m_hi, m_lo} = p;
            3'd5: {m_hi, m_lo} = acc + p;
            3'd6: {m_hi, m_lo} = acc - p;
            3'd3: m_hi = a;
            3'd4: m_lo = a;
            3'd2: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else if (sg) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] fn);
        if (fn == 3'd1 || fn == 3'd5 || fn == 3'd6) return LAT;
        if (fn == 3'd2) return W + 1;
        return 0;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 100));
            default: return 32'($urandom);
        endcase
    endfunction

    // Caller is at a negedge; leaves the bench at the negedge right after the
    // accepting edge.
    task automatic issue(input logic [2:0] fn, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.func   = fn;
        bus.isSign = sg;
        bus.a      = a;
        bus.b      = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Samples n negedges starting with the current one.
    task automatic wait_op(input int n, output int bc, output int dc, output int da);
        bc = 0;
        dc = 0;
        da = 0;
        for (int s = 1; s <= n; s++) begin
            if (s > 1) @(negedge clk);
            if (bus.busy === 1'b1) bc++;
            if (bus.done === 1'b1) begin
                dc++;
                da = s;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.func   = 3'd0;
        bus.isSign = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mult_vector();
        int bc, dc, da;
        @(negedge clk);
        issue(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
        model_op(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
        wait_op(LAT + 3, bc, dc, da);
        total++; if (bc != LAT) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bc, LAT); end
        total++; if (dc != 1) begin bad++; $display("FAIL mult_done_count got=%0d exp=1", dc); end
        total++; if (da != LAT + 1) begin bad++; $display("FAIL mult_done_time got=%0d exp=%0d", da, LAT + 1); end
        total++; if (bus.hi !== m_hi) begin bad++; $display("FAIL mult_hi got=%h exp=%h", bus.hi, m_hi); end
        total++; if (bus.lo !== m_lo) begin bad++; $display("FAIL mult_lo got=%h exp=%h", bus.lo, m_lo); end
    endtask

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
    } dvec_t;

    task automatic test_div_vectors();
        dvec_t dv[6];
        int bc, dc, da;
        dv[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2};
        dv[1] = '{1'b0, 32'hFFFF_FFF9, 32'd2};
        dv[2] = '{1'b0, 32'h0000_1234, 32'd0};
        dv[3] = '{1'b1, 32'hFFFF_1234, 32'd0};
        dv[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
        dv[5] = '{1'b1, 32'd100, 32'hFFFF_FFF9};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(3'd2, dv[i].sg, dv[i].a, dv[i].b);
            model_op(3'd2, dv[i].sg, dv[i].a, dv[i].b);
            wait_op(W + 4, bc, dc, da);
            total++; if (bc != W + 1) begin bad++; $display("FAIL div%0d_busy_cycles got=%0d exp=%0d", i, bc, W + 1); end
            total++; if (dc != 1 || da != W + 2) begin bad++; $display("FAIL div%0d_done got=%0d@%0d exp=1@%0d", i, dc, da, W + 2); end
            total++; if (bus.hi !== m_hi) begin bad++; $display("FAIL div%0d_hi got=%h exp=%h", i, bus.hi, m_hi); end
            total++; if (bus.lo !== m_lo) begin bad++; $display("FAIL div%0d_lo got=%h exp=%h", i, bus.lo, m_lo); end
        end
    endtask

    task automatic test_mt_madd_msub();
        int bc, dc, da;
        @(negedge clk);
        issue(3'd3, 1'b0, 32'd0, 32'd9);
        model_op(3'd3, 1'b0, 32'd0, 32'd9);
        total++; if (bus.hi !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin bad++; $display("FAIL mthi got hi=%h busy=%b done=%b exp hi=0 busy=0 done=0", bus.hi, bus.busy, bus.done); end
        issue(3'd4, 1'b0, 32'd5, 32'd9);
        model_op(3'd4, 1'b0, 32'd5, 32'd9);
        total++; if (bus.lo !== 32'd5 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin bad++; $display("FAIL mtlo got lo=%h busy=%b done=%b exp lo=5 busy=0 done=0", bus.lo, bus.busy, bus.done); end
        @(negedge clk);
        issue(3'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        model_op(3'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_op(LAT + 2, bc, dc, da);
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL madd got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(negedge clk);
        issue(3'd6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        model_op(3'd6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_op(LAT + 2, bc, dc, da);
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL msub got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        total++; if (dc != 1) begin bad++; $display("FAIL msub_done_count got=%0d exp=1", dc); end
    endtask

    task automatic test_random();
        int bc, dc, da, eb, n;
        logic [2:0]   fn;
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 40; i++) begin
            fn = 3'($urandom_range(0, 7));
            sg = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            @(negedge clk);
            issue(fn, sg, a, b);
            model_op(fn, sg, a, b);
            eb = exp_busy(fn);
            n  = (eb == 0) ? 2 : eb + 3;
            wait_op(n, bc, dc, da);
            total++; if (bc != eb) begin bad++; $display("FAIL rnd%0d_busy fn=%0d got=%0d exp=%0d", i, fn, bc, eb); end
            total++; if (dc != ((eb == 0) ? 0 : 1) || (eb != 0 && da != eb + 1))
                begin bad++; $display("FAIL rnd%0d_done fn=%0d got=%0d@%0d exp_busy=%0d", i, fn, dc, da, eb); end
            total++; if (bus.hi !== m_hi || bus.lo !== m_lo)
                begin bad++; $display("FAIL rnd%0d_hilo fn=%0d sg=%b a=%h b=%h got=%h_%h exp=%h_%h", i, fn, sg, a, b, bus.hi, bus.lo, m_hi, m_lo); end
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc, da;
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = pick();
        b = pick();
        @(negedge clk);
        issue(3'd1, 1'b1, a, b);
        model_op(3'd1, 1'b1, a, b);
        wait_op(LAT, bc, dc, da);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b1)
            begin bad++; $display("FAIL b2b_first_done got busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done); end
        issue(3'd5, 1'b0, b, a);
        model_op(3'd5, 1'b0, b, a);
        wait_op(LAT + 2, bc, dc, da);
        total++; if (bc != LAT || dc != 1 || da != LAT + 1)
            begin bad++; $display("FAIL b2b_second got busy=%0d done=%0d@%0d exp busy=%0d done=1@%0d", bc, dc, da, LAT, LAT + 1); end
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL b2b_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_start_while_busy();
        int bc, dc, da;
        @(negedge clk);
        issue(3'd1, 1'b0, 32'd1000, 32'd3000);
        model_op(3'd1, 1'b0, 32'd1000, 32'd3000);
        @(negedge clk);
        bus.func  = 3'd4;
        bus.a     = 32'h77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_op(4, bc, dc, da);
        total++; if (dc != 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=1", dc); end
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL busy_start_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_flush();
        int bc, dc, da;
        @(negedge clk);
        issue(3'd3, 1'b0, 32'hAAAA_0001, 32'd0);
        model_op(3'd3, 1'b0, 32'hAAAA_0001, 32'd0);
        issue(3'd4, 1'b0, 32'h5555_0002, 32'd0);
        model_op(3'd4, 1'b0, 32'h5555_0002, 32'd0);
        issue(3'd2, 1'b1, 32'hFFFF_FF00, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.func  = 3'd3;
        bus.a     = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_div_busy got=%b exp=0", bus.busy); end
        wait_op(W + 4, bc, dc, da);
        total++; if (dc != 0 || bc != 0) begin bad++; $display("FAIL flush_div_after got busy=%0d done=%0d exp 0 0", bc, dc); end
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL flush_div_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(negedge clk);
        issue(3'd5, 1'b0, 32'd12345, 32'd678);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_op(LAT + 3, bc, dc, da);
        total++; if (dc != 0 || bc != 0) begin bad++; $display("FAIL flush_mul_after got busy=%0d done=%0d exp 0 0", bc, dc); end
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL flush_mul_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        int bc, dc, da;
        @(negedge clk);
        issue(3'd3, 1'b0, 32'h1111, 32'd0);
        issue(3'd1, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
        @(negedge clk);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        wait_op(LAT + 3, bc, dc, da);
        total++; if (dc != 0 || bc != 0) begin bad++; $display("FAIL rst_mid_after got busy=%0d done=%0d exp 0 0", bc, dc); end
        total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL rst_mid_final got=%h_%h exp=0_0", bus.hi, bus.lo); end
    endtask

    initial begin
        test_reset();
        test_mult_vector();
        test_div_vectors();
        test_mt_madd_msub();
        test_back_to_back();
        test_start_while_busy();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
